// File: rtl/core_defines.sv
// Shared core definitions for the tiny 5-stage core.
// Provides the default datapath widths, the hard-wired zero register
// address and the level at which the synchronous reset is asserted.
package core_defines;

  localparam int DW = 32;
  localparam int AW = 5;

  localparam logic [4:0] ZERO_REG   = 5'd0;
  localparam logic       RST_ACTIVE = 1'b0;

endpackage

// File: rtl/ex_wb_entry.sv
// One registered result slot of the ex/wb skid buffer.
// Ports:
//   clk, rst      clock, synchronous active-low reset (clears valid only)
//   load          capture d and take load_vld as the new valid bit
//   load_vld      valid bit written on load
//   clear         invalidate the slot; wins over load
//   d             packed entry payload
//   vld           slot holds a live result
//   q             packed entry payload
module ex_wb_entry
  import core_defines::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         load_vld,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic         vld,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst == RST_ACTIVE) begin
      vld <= 1'b0;
    end else if (clear) begin
      vld <= 1'b0;
    end else if (load) begin
      vld <= load_vld;
    end
  end

  // Payload is never reset: it is only observed while vld is set.
  always_ff @(posedge clk) begin
    if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/ex_wb.sv
// ex -> wb pipeline register with a two-entry skid buffer.
// Head entry H drives wb; skid entry S absorbs one extra result while wb is
// held. Wrong-path results behind a committing jump are squashed, x0 writes
// are dropped on entry, and committed results are counted.
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   in_valid_i / in_ready_o  ex handshake (ready depends on registered state only)
//   reg_wdata_i, reg_we_i, reg_waddr_i, jump_flag_i, jump_addr_i  ex result
//   hold_i, flush_i          ctrl hold (wb not ready) and flush
//   out_valid_o              H holds a result
//   reg_wdata_o, reg_we_o, reg_waddr_o, jump_flag_o, jump_addr_o  to wb
//   retired_o                committed-result count (wraps)
module ex_wb
  import core_defines::*;
#(
  parameter int DW    = core_defines::DW,
  parameter int AW    = core_defines::AW,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [DW-1:0]    reg_wdata_i,
  input  logic             reg_we_i,
  input  logic [AW-1:0]    reg_waddr_i,
  input  logic             jump_flag_i,
  input  logic [DW-1:0]    jump_addr_i,
  input  logic             hold_i,
  input  logic             flush_i,
  output logic             out_valid_o,
  output logic [DW-1:0]    reg_wdata_o,
  output logic             reg_we_o,
  output logic [AW-1:0]    reg_waddr_o,
  output logic             jump_flag_o,
  output logic [DW-1:0]    jump_addr_o,
  output logic [CNT_W-1:0] retired_o
);

  localparam int EW = 2 * DW + AW + 2;

  logic          accept;
  logic          commit;
  logic          squash;
  logic          in_we;
  logic [EW-1:0] in_ent;

  logic          h_vld_p1;
  logic [EW-1:0] h_q_p1;
  logic          h_load;
  logic          h_load_vld;
  logic          h_clear;
  logic [EW-1:0] h_d;

  logic          s_vld_p1;
  logic [EW-1:0] s_q_p1;
  logic          s_load;
  logic          s_clear;

  logic [DW-1:0] h_wdata;
  logic          h_we;
  logic [AW-1:0] h_waddr;
  logic          h_jflag;
  logic [DW-1:0] h_jaddr;

  logic [CNT_W-1:0] retired_p1;

  assign in_ready_o = !s_vld_p1;
  assign accept     = in_valid_i & in_ready_o;
  assign commit     = h_vld_p1 & !hold_i;
  // A committing jump makes everything behind it wrong-path.
  assign squash     = commit & h_jflag;

  // x0 is hard-wired zero, so its write enable is dropped at entry.
  assign in_we  = reg_we_i & (reg_waddr_i != AW'(ZERO_REG));
  assign in_ent = {reg_wdata_i, in_we, reg_waddr_i, jump_flag_i, jump_addr_i};

  // H refills whenever it empties or is consumed: from S if S is live,
  // otherwise from the incoming result. S only ever fills while H is stalled.
  assign h_clear    = flush_i | squash;
  assign h_load     = commit | !h_vld_p1;
  assign h_d        = s_vld_p1 ? s_q_p1 : in_ent;
  assign h_load_vld = s_vld_p1 | accept;

  assign s_clear = flush_i | commit;
  assign s_load  = h_vld_p1 & !commit & accept;

  // ---- stage boundary: ex inputs -> H/S registers ----
  ex_wb_entry #(.W(EW)) u_head (
    .clk      (clk),
    .rst      (rst),
    .load     (h_load),
    .load_vld (h_load_vld),
    .clear    (h_clear),
    .d        (h_d),
    .vld      (h_vld_p1),
    .q        (h_q_p1)
  );

  ex_wb_entry #(.W(EW)) u_skid (
    .clk      (clk),
    .rst      (rst),
    .load     (s_load),
    .load_vld (1'b1),
    .clear    (s_clear),
    .d        (in_ent),
    .vld      (s_vld_p1),
    .q        (s_q_p1)
  );

  always_ff @(posedge clk) begin
    if (rst == RST_ACTIVE) begin
      retired_p1 <= '0;
    end else if (commit) begin
      retired_p1 <= retired_p1 + CNT_W'(1);
    end
  end

  // ---- stage boundary: H register -> wb outputs ----
  assign {h_wdata, h_we, h_waddr, h_jflag, h_jaddr} = h_q_p1;

  assign out_valid_o = h_vld_p1;
  assign reg_we_o    = commit & h_we;
  assign jump_flag_o = commit & h_jflag;
  assign reg_wdata_o = h_vld_p1 ? h_wdata : '0;
  assign reg_waddr_o = h_vld_p1 ? h_waddr : '0;
  assign jump_addr_o = h_vld_p1 ? h_jaddr : '0;
  assign retired_o   = retired_p1;

endmodule

// File: tb/tb_ex_wb.sv
// Scoreboard bench for ex_wb: a queue-based reference model predicts the
// buffered results and every commit; a monitor compares DUT outputs.
module tb_ex_wb;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] reg_wdata_i;
  logic        reg_we_i;
  logic [4:0]  reg_waddr_i;
  logic        jump_flag_i;
  logic [31:0] jump_addr_i;
  logic        hold_i;
  logic        flush_i;
  logic        out_valid_o;
  logic [31:0] reg_wdata_o;
  logic        reg_we_o;
  logic [4:0]  reg_waddr_o;
  logic        jump_flag_o;
  logic [31:0] jump_addr_o;
  logic [31:0] retired_o;

  ex_wb dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .reg_wdata_i (reg_wdata_i),
    .reg_we_i    (reg_we_i),
    .reg_waddr_i (reg_waddr_i),
    .jump_flag_i (jump_flag_i),
    .jump_addr_i (jump_addr_i),
    .hold_i      (hold_i),
    .flush_i     (flush_i),
    .out_valid_o (out_valid_o),
    .reg_wdata_o (reg_wdata_o),
    .reg_we_o    (reg_we_o),
    .reg_waddr_o (reg_waddr_o),
    .jump_flag_o (jump_flag_o),
    .jump_addr_o (jump_addr_o),
    .retired_o   (retired_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] wdata;
    logic        we;
    logic [4:0]  waddr;
    logic        jflag;
    logic [31:0] jaddr;
  } res_t;

  res_t mq[$];      // results buffered in the stage, oldest first
  res_t exp_q[$];   // expected commits, in order
  logic [31:0] m_ret = 0;
  bit   known = 0;

  // Expectations for the cycle just driven
  bit    chk_en = 0;
  bit    exp_ready, exp_ovalid;
  logic [31:0] exp_retired;
  res_t  exp_head;
  event  drv_ev;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus and advance the reference model.
  task automatic cycle(input bit rst_n, input bit vld, input bit we,
                       input logic [4:0] waddr, input logic [31:0] wdata,
                       input bit jf, input logic [31:0] ja,
                       input bit hold, input bit flush);
    res_t r;
    res_t h;
    bit   do_commit;
    bit   acc;
    @(negedge clk);
    rst = rst_n; in_valid_i = vld; reg_we_i = we; reg_waddr_i = waddr;
    reg_wdata_i = wdata; jump_flag_i = jf; jump_addr_i = ja;
    hold_i = hold; flush_i = flush;

    chk_en      = known;
    exp_ready   = (mq.size() < 2);
    exp_ovalid  = (mq.size() > 0);
    exp_retired = m_ret;
    exp_head    = (mq.size() > 0) ? mq[0] : '0;

    do_commit = (mq.size() > 0) && !hold;
    if (do_commit && known) exp_q.push_back(mq[0]);
    acc = vld && exp_ready;
    r.wdata = wdata; r.we = we && (waddr != 0); r.waddr = waddr;
    r.jflag = jf; r.jaddr = ja;

    if (!rst_n) begin
      mq.delete();
      m_ret = 0;
      known = 1;
    end else begin
      if (do_commit) begin
        h = mq.pop_front();
        m_ret = m_ret + 1;
        if (h.jflag) begin
          mq.delete();
          acc = 0;
        end
      end
      if (acc) mq.push_back(r);
      if (flush) mq.delete();
    end
    -> drv_ev;
  endtask

  task automatic idle(input bit hold);
    cycle(1, 0, 0, 5'd0, 32'h0, 0, 32'h0, hold, 0);
  endtask

  // Monitor: compares outputs once inputs of each cycle have settled.
  always begin
    res_t e;
    @(drv_ev);
    #2;
    if (chk_en) begin
      chk("in_ready", in_ready_o, exp_ready);
      chk("out_valid", out_valid_o, exp_ovalid);
      chk("retired", retired_o, exp_retired);
      chk("head_wdata", reg_wdata_o, exp_head.wdata);
      chk("head_waddr", reg_waddr_o, exp_head.waddr);
      chk("head_jaddr", jump_addr_o, exp_head.jaddr);
      if (out_valid_o && !hold_i) begin
        if (exp_q.size() == 0) begin
          chk("commit_expected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("commit_we", reg_we_o, e.we);
          chk("commit_jflag", jump_flag_o, e.jflag);
          chk("commit_wdata", reg_wdata_o, e.wdata);
          chk("commit_waddr", reg_waddr_o, e.waddr);
          chk("commit_jaddr", jump_addr_o, e.jaddr);
        end
      end else begin
        chk("idle_we", reg_we_o, 0);
        chk("idle_jflag", jump_flag_o, 0);
      end
    end
  end

  initial begin
    rst = 1'b0; in_valid_i = 0; reg_we_i = 0; reg_waddr_i = 0; reg_wdata_i = 0;
    jump_flag_i = 0; jump_addr_i = 0; hold_i = 0; flush_i = 0;

    // Reset with a valid result offered
    cycle(0, 1, 1, 5'd3, 32'h33, 0, 0, 0, 0);
    cycle(0, 1, 1, 5'd3, 32'h33, 0, 0, 0, 0);

    // Streaming
    for (int i = 1; i <= 4; i++)
      cycle(1, 1, 1, 5'(i), 32'h11 * i, 0, 0, 0, 0);
    idle(0); idle(0);

    // Hold / skid
    cycle(1, 1, 1, 5'd5, 32'hA, 0, 0, 1, 0);
    cycle(1, 1, 1, 5'd6, 32'hB, 0, 0, 1, 0);
    cycle(1, 1, 1, 5'd7, 32'hC, 0, 0, 1, 0);
    idle(0); idle(0); idle(0);

    // x0 suppression
    cycle(1, 1, 1, 5'd0, 32'hDEAD, 0, 0, 0, 0);
    idle(0); idle(0);

    // Jump squash: H = jump, S = C, D offered at commit
    cycle(1, 1, 0, 5'd0, 32'h0, 1, 32'h80, 1, 0);
    cycle(1, 1, 1, 5'd8, 32'hC, 0, 0, 1, 0);
    cycle(1, 1, 1, 5'd9, 32'hD, 0, 0, 0, 0);
    idle(0); idle(0);

    // Flush with both entries full and hold asserted
    cycle(1, 1, 1, 5'd10, 32'hE, 0, 0, 1, 0);
    cycle(1, 1, 1, 5'd11, 32'hF, 0, 0, 1, 0);
    cycle(1, 0, 0, 5'd0, 32'h0, 0, 0, 1, 1);
    idle(0); idle(0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      cycle(($urandom_range(0, 99) < 99),
            ($urandom_range(0, 99) < 70),
            ($urandom_range(0, 99) < 80),
            5'($urandom_range(0, 31)),
            $urandom,
            ($urandom_range(0, 99) < 15),
            $urandom,
            ($urandom_range(0, 99) < 30),
            ($urandom_range(0, 99) < 5));
    end

    // Drain
    idle(0); idle(0); idle(0); idle(0);
    #5;
    chk("scoreboard_drain", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_wb.md
Name: ex_wb

Overview:
- Pipeline register stage between ex (upstream) and wb (downstream) in the tiny 5-stage core; the core has no data-memory stage.
- Registers ex results (register write and jump) and presents them to wb.
- Two-entry skid buffer with valid/ready handshake, so a ctrl hold never drops a result.
- Squashes wrong-path results when a jump commits, suppresses x0 writes, and counts retired results.

Parameters:
- DW, 32, data/address width
- AW, 5, register address width
- CNT_W, 32, retired-counter width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- in_valid_i  in  1  ex result valid
- in_ready_o  out  1  stage can accept
- reg_wdata_i  in  DW  register write data
- reg_we_i  in  1  register write enable
- reg_waddr_i  in  AW  register write address
- jump_flag_i  in  1  result is a taken jump
- jump_addr_i  in  DW  jump target
- hold_i  in  1  ctrl hold; wb not ready
- flush_i  in  1  ctrl flush of stage contents
- out_valid_o  out  1  head entry valid
- reg_wdata_o  out  DW  to wb
- reg_we_o  out  1  to wb; commit-qualified
- reg_waddr_o  out  AW  to wb
- jump_flag_o  out  1  to wb; commit-qualified
- jump_addr_o  out  DW  to wb
- retired_o  out  CNT_W  committed-result count

Behaviour:
- Storage: head entry H and skid entry S. Each entry holds {valid, wdata, we, waddr, jflag, jaddr}.
- Reset (rst==0 at clk edge):
  - H.valid=0, S.valid=0, retired_o=0.
  - All outputs 0; in_ready_o=1.
  - Reset mid-operation discards both entries without commit.
- Handshakes:
  - in_ready_o = !S.valid (registered-state based; no combinational path from hold_i).
  - Accept = in_valid_i & in_ready_o.
  - Commit = H.valid & !hold_i.
- Entry write rule: on accept, store we as reg_we_i & (reg_waddr_i!=0), so x0 is never written.
- Data movement each edge (flush_i=0):
  - Commit, S valid: H<=S; S<=incoming if accepted, else invalid.
  - Commit, S empty: H<=incoming if accepted, else invalid.
  - No commit, H empty: H<=incoming.
  - No commit, H valid: S<=incoming if accepted.
- Latency: an accepted result is visible on out_valid_o the next cycle. With no hold, throughput is 1 per cycle.
- Commit-qualified outputs:
  - reg_we_o = Commit & H.we.
  - jump_flag_o = Commit & H.jflag.
  - reg_wdata_o, reg_waddr_o, jump_addr_o come from H, and are 0 when H is invalid.
- Jump squash: when Commit & H.jflag, S is invalidated and any same-cycle accepted input is dropped (wrong path). Next state: H and S empty.
- flush_i=1:
  - Both entries are invalidated at the edge; flush has priority over accept.
  - Same-cycle commit outputs still assert, because wb consumes H combinationally.
- retired_o increments by 1 per Commit. It wraps modulo 2^CNT_W and is not cleared by flush.
- No data is lost while hold_i=1. At most 2 results are buffered, and in_ready_o=0 while S is valid.

Decomposition:
- Shared core package (core_defines): DW/AW widths, ZERO_REG=5'd0, reset level constant (RST_ACTIVE=1'b0).
- Optional sub-module: ex_wb_entry (one registered slot with load/clear/valid). Instance it twice, for H and S.

Test Plan:
- Reset: rst=0 for 2 cycles while in_valid_i=1 -> out_valid_o=0, reg_we_o=0, retired_o=0, in_ready_o=1.
- Streaming: 4 back-to-back results, hold_i=0, waddr=1..4, wdata=0x11..0x44 -> each seen 1 cycle later with reg_we_o=1; retired_o=4.
- Hold/skid: hold_i=1 for 3 cycles while sending A(x5, 0xA) and B(x6, 0xB) -> in_ready_o=0 after B; reg_we_o=0 during hold. Release -> A then B committed in order, nothing dropped.
- x0 suppression: reg_we_i=1, reg_waddr_i=0, wdata=0xDEAD -> out_valid_o=1 but reg_we_o=0; retired_o still increments.
- Jump squash: H=jump to 0x80, S holds C, input D offered same cycle -> jump_flag_o=1, jump_addr_o=0x80. C and D are never committed; stage empty next cycle.
- Flush: both entries full, flush_i=1 with hold_i=1 -> next cycle out_valid_o=0, in_ready_o=1, retired_o unchanged.
